// File: rtl/dmem_bus_pkg.sv
// Shared types and constants for the data-memory bus bridge between the LSU and data memory.
package dmem_bus_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_BE_W   = BUS_DATA_W / 8;

  // LSU strobes are active-low.
  localparam logic CS_ACTIVE = 1'b0;
  localparam logic WR_STORE  = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } dmem_state_e;

  typedef struct packed {
    logic                  we;
    logic [BUS_BE_W-1:0]   be;
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] wdata;
  } dmem_req_t;

  function automatic logic [BUS_ADDR_W-1:0] word_align(input logic [BUS_ADDR_W-1:0] a);
    return {a[BUS_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/dmem_timeout_ctr.sv
// Counts cycles of an outstanding bus access and flags the cycle in which the limit is reached.
module dmem_timeout_ctr #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((LIMIT > 0) ? LIMIT - 1 : 0);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + 1'b1;
  end

  // Expiring on LAST means exactly LIMIT enabled cycles have elapsed; LIMIT of 0 never expires.
  assign expire = (LIMIT != 0) && enable && (count == LAST);

endmodule

// File: rtl/dmem_bus_ctrl.sv
// LSU-to-data-memory bridge: one valid/ready request plus one response per access,
// stalling the pipeline while the access is outstanding and flagging errors/timeouts.
module dmem_bus_ctrl
  import dmem_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cs,
  input  logic                wr,
  input  logic [DATA_W/8-1:0] mask,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   data_wr,
  output logic [DATA_W-1:0]   data_rd,
  output logic                stall,
  output logic                access_fault,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_we,
  output logic [DATA_W/8-1:0] mem_req_be,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_wdata,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_rdata,
  input  logic                mem_rsp_err
);

  dmem_state_e state;
  dmem_req_t   req;
  logic        access_req;
  logic        zero_store;
  logic        start_req;
  logic        expire;

  // NOTE: every signal gets a value on every path through always_comb, so no latch is inferred.
  always_comb begin
    access_req = (state == IDLE) && (cs == CS_ACTIVE);
    zero_store = (wr == WR_STORE) && (mask == '0);
    start_req  = access_req && !zero_store;
  end

  assign stall = access_req || (state == REQ) || (state == WAIT);

  dmem_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (start_req),
    .enable ((state == REQ) || (state == WAIT)),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      req           <= '0;
      mem_req_valid <= 1'b0;
      data_rd       <= '0;
      access_fault  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          access_fault <= 1'b0;
          if (access_req) begin
            req.we    <= (wr == WR_STORE);
            req.be    <= BUS_BE_W'(mask);
            req.addr  <= word_align(BUS_ADDR_W'(addr));
            req.wdata <= BUS_DATA_W'(data_wr);
            if (zero_store) begin
              data_rd <= '0;
              state   <= RESP;
            end else begin
              mem_req_valid <= 1'b1;
              state         <= REQ;
            end
          end
        end
        REQ: begin
          // Timeout wins over a same-cycle handshake; any later response is then ignored.
          if (expire) begin
            mem_req_valid <= 1'b0;
            data_rd       <= '0;
            access_fault  <= 1'b1;
            state         <= RESP;
          end else if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            data_rd      <= (mem_rsp_err || req.we) ? '0 : mem_rsp_rdata;
            access_fault <= mem_rsp_err;
            state        <= RESP;
          end else if (expire) begin
            data_rd      <= '0;
            access_fault <= 1'b1;
            state        <= RESP;
          end
        end
        RESP: begin
          // cs still belongs to the retiring instruction here, so it is not sampled.
          access_fault <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          mem_req_valid <= 1'b0;
          access_fault  <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

  assign mem_req_we    = req.we;
  assign mem_req_be    = req.be[DATA_W/8-1:0];
  assign mem_req_addr  = req.addr[ADDR_W-1:0];
  assign mem_req_wdata = req.wdata[DATA_W-1:0];

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Scoreboarded bench for dmem_bus_ctrl: directed accesses push expected responses,
// a monitor pops them whenever the controller retires an access.
module tb_dmem_bus_ctrl;

  logic        clk;
  logic        rst;
  logic        cs;
  logic        wr;
  logic [3:0]  mask;
  logic [31:0] addr;
  logic [31:0] data_wr;
  logic [31:0] data_rd;
  logic        stall;
  logic        access_fault;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [3:0]  mem_req_be;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        mem_rsp_err;

  dmem_bus_ctrl #(
    .TIMEOUT_CYCLES (8),
    .ADDR_W         (32),
    .DATA_W         (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cs            (cs),
    .wr            (wr),
    .mask          (mask),
    .addr          (addr),
    .data_wr       (data_wr),
    .data_rd       (data_rd),
    .stall         (stall),
    .access_fault  (access_fault),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_we    (mem_req_we),
    .mem_req_be    (mem_req_be),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata),
    .mem_rsp_err   (mem_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        fault;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory model configuration, set by the stimulus before each access.
  int          ready_delay  = 0;
  logic        rsp_en       = 1'b1;
  logic        rsp_err_cfg  = 1'b0;
  logic [31:0] rsp_data_cfg = '0;
  logic        stray_req    = 1'b0;

  initial begin
    int   wait_cnt;
    logic hs;
    wait_cnt      = 0;
    hs            = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
    mem_rsp_err   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      mem_rsp_valid = 1'b0;
      mem_rsp_rdata = '0;
      mem_rsp_err   = 1'b0;
      if (hs && rsp_en) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = rsp_data_cfg;
        mem_rsp_err   = rsp_err_cfg;
      end
      if (stray_req) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'hBAD0BAD0;
        stray_req     = 1'b0;
      end
      hs            = 1'b0;
      mem_req_ready = 1'b0;
      if (mem_req_valid && !rst) begin
        if (wait_cnt >= ready_delay) begin
          mem_req_ready = 1'b1;
          hs            = 1'b1;
          wait_cnt      = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // A retiring access shows up as stall falling; that cycle is RESP.
  initial begin
    logic prev_stall;
    exp_t e;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && !stall) begin
          if (sb.size() == 0) begin
            check("unexpected_resp", 32'(access_fault), 32'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            check("resp_data_rd", data_rd, e.data);
            check("resp_fault", 32'(access_fault), 32'(e.fault));
          end
        end else begin
          check("fault_outside_resp", 32'(access_fault), 32'd0);
        end
        prev_stall = stall;
      end
    end
  end

  int          res_stall;
  int          res_valid;
  int          res_unstable;
  logic        res_done;
  logic [31:0] res_addr;
  logic [3:0]  res_be;
  logic        res_we;
  logic [31:0] res_wdata;

  // Called just after a rising edge with the controller in IDLE; returns just after the
  // edge that leaves RESP, with cs released.
  task automatic run_access(input logic w, input logic [3:0] m, input logic [31:0] a,
                            input logic [31:0] d);
    cs = 1'b0; wr = w; mask = m; addr = a; data_wr = d;
    res_stall = 0; res_valid = 0; res_unstable = 0; res_done = 1'b0;
    res_addr = '0; res_be = '0; res_we = 1'b0; res_wdata = '0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (mem_req_valid) begin
        if (res_valid == 0) begin
          res_addr = mem_req_addr; res_be = mem_req_be;
          res_we = mem_req_we; res_wdata = mem_req_wdata;
        end else if (mem_req_addr !== res_addr || mem_req_be !== res_be ||
                     mem_req_we !== res_we || mem_req_wdata !== res_wdata) begin
          res_unstable++;
        end
        res_valid++;
      end
      if (!stall) begin
        res_done = 1'b1;
        break;
      end
      res_stall++;
    end
    check("access_completes", 32'(res_done), 32'd1);
    @(posedge clk);
    #1;
    cs = 1'b1; wr = 1'b1; mask = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    cs = 1'b1; wr = 1'b1; mask = '0; addr = '0; data_wr = '0; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data_rd", data_rd, 32'd0);
    check("rst_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_req_addr", mem_req_addr, 32'd0);
    check("rst_req_be_we", {27'd0, mem_req_be, mem_req_we}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Load, ready and response at first opportunity.
    ready_delay = 0; rsp_en = 1'b1; rsp_err_cfg = 1'b0; rsp_data_cfg = 32'hDEADBEEF;
    sb.push_back('{data: 32'hDEADBEEF, fault: 1'b0});
    run_access(1'b1, 4'hF, 32'h0000_0104, 32'h0);
    check("load_stall_cycles", 32'(res_stall), 32'd3);
    check("load_valid_cycles", 32'(res_valid), 32'd1);
    check("load_req_addr", res_addr, 32'h0000_0104);
    check("load_req_we", 32'(res_we), 32'd0);

    // Byte store, ready withheld for five request cycles.
    ready_delay = 5; rsp_data_cfg = 32'h5555_5555;
    sb.push_back('{data: 32'h0, fault: 1'b0});
    run_access(1'b0, 4'b0100, 32'h0000_0203, 32'h00AB_0000);
    check("bstore_stall_cycles", 32'(res_stall), 32'd8);
    check("bstore_valid_cycles", 32'(res_valid), 32'd6);
    check("bstore_payload_stable", 32'(res_unstable), 32'd0);
    check("bstore_req_addr", res_addr, 32'h0000_0200);
    check("bstore_req_be", 32'(res_be), 32'h4);
    check("bstore_req_we", 32'(res_we), 32'd1);
    check("bstore_req_wdata", res_wdata, 32'h00AB_0000);

    // Zero-mask store never reaches the bus.
    ready_delay = 0;
    sb.push_back('{data: 32'h0, fault: 1'b0});
    run_access(1'b0, 4'b0000, 32'h0000_0300, 32'hFFFF_FFFF);
    check("zstore_stall_cycles", 32'(res_stall), 32'd1);
    check("zstore_valid_cycles", 32'(res_valid), 32'd0);

    // Bus error on a load.
    rsp_err_cfg = 1'b1; rsp_data_cfg = 32'h1234_5678;
    sb.push_back('{data: 32'h0, fault: 1'b1});
    run_access(1'b1, 4'hF, 32'h0000_0040, 32'h0);
    check("err_stall_cycles", 32'(res_stall), 32'd3);
    rsp_err_cfg = 1'b0;

    // Timeout: ready never comes, then a late response arrives in IDLE.
    ready_delay = 1000;
    sb.push_back('{data: 32'h0, fault: 1'b1});
    run_access(1'b1, 4'hF, 32'h0000_0500, 32'h0);
    check("tmo_valid_cycles", 32'(res_valid), 32'd8);
    check("tmo_stall_cycles", 32'(res_stall), 32'd9);
    repeat (2) @(posedge clk);
    #1;
    stray_req = 1'b1;
    repeat (3) @(negedge clk);
    check("tmo_late_data_rd", data_rd, 32'd0);
    check("tmo_late_idle", {30'd0, stall, mem_req_valid}, 32'd0);

    // Load that leaves a non-zero data_rd ahead of the reset test.
    ready_delay = 0; rsp_data_cfg = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    sb.push_back('{data: 32'hCAFE_F00D, fault: 1'b0});
    run_access(1'b1, 4'hF, 32'h0000_0600, 32'h0);

    // Reset while waiting for a response that never comes.
    rsp_en = 1'b0;
    cs = 1'b0; wr = 1'b1; mask = 4'hF; addr = 32'h0000_0700;
    repeat (2) @(posedge clk);
    #1;
    check("prerst_in_wait", {30'd0, stall, mem_req_valid}, 32'd2);
    check("prerst_data_rd", data_rd, 32'hCAFE_F00D);
    #2;
    rst = 1'b1; cs = 1'b1;
    #1;
    check("midrst_req_valid", 32'(mem_req_valid), 32'd0);
    check("midrst_stall", 32'(stall), 32'd0);
    check("midrst_data_rd", data_rd, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    stray_req = 1'b1;
    repeat (3) @(negedge clk);
    check("postrst_stray_data_rd", data_rd, 32'd0);
    check("postrst_stray_idle", {30'd0, stall, mem_req_valid}, 32'd0);

    // Next load after reset completes normally.
    rsp_en = 1'b1; rsp_data_cfg = 32'h0BAD_F00D;
    @(posedge clk);
    #1;
    sb.push_back('{data: 32'h0BAD_F00D, fault: 1'b0});
    run_access(1'b1, 4'hF, 32'h0000_0807, 32'h0);
    check("postrst_load_stall", 32'(res_stall), 32'd3);
    check("postrst_load_addr", res_addr, 32'h0000_0804);

    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_bus_ctrl.md
Name: dmem_bus_ctrl

Overview:
Sequential bridge directly downstream of the load/store unit. It captures the LSU's chip-select, write, byte-mask, address and write-data outputs, runs a valid/ready request plus response transaction to data memory, and stalls the pipeline while the transaction is outstanding. It returns the memory word to the LSU's data_rd input for load extraction, and flags bus errors and timeouts as an access fault.

Parameters:
TIMEOUT_CYCLES, 255, cycles allowed in REQ+WAIT before abort; 0 disables the timeout.
ADDR_W, 32, address width.
DATA_W, 32, data width; mask width is DATA_W/8.

Ports:
clk  in  1  core clock.
rst  in  1  asynchronous, active-high reset.
cs  in  1  LSU chip select, active-low (0 = access this cycle).
wr  in  1  LSU write strobe, active-low (0 = store, 1 = load).
mask  in  4  LSU byte enables (store).
addr  in  32  LSU byte address.
data_wr  in  32  LSU lane-aligned store data.
data_rd  out  32  raw memory word to LSU (registered).
stall  out  1  freeze upstream pipeline.
access_fault  out  1  one-cycle pulse: error or timeout on this access.
mem_req_valid  out  1  request valid.
mem_req_ready  in  1  memory accepts request.
mem_req_we  out  1  1 = write (active-high on the bus side).
mem_req_be  out  4  byte enables.
mem_req_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
mem_req_wdata  out  32  write data.
mem_rsp_valid  in  1  response/ack valid.
mem_rsp_rdata  in  32  read data.
mem_rsp_err  in  1  bus error, qualified by mem_rsp_valid.

Behaviour:
- Reset (async, immediate): state=IDLE; data_rd=0, access_fault=0, mem_req_* = 0, timeout counter=0. Reset mid-transaction abandons it. mem_req_valid drops at once.
- States: IDLE, REQ, WAIT, RESP.
- IDLE: if cs==0, register we=~wr, be, aligned addr, wdata; stall=1 combinationally.
  - Load, or store with mask!=0: go to REQ.
  - Store with mask==0: no bus transaction; go to RESP with data_rd=0.
  - cs==1 or X-free non-zero: stay in IDLE, stall=0.
- REQ: mem_req_valid=1, payload driven from registers and stable until accepted; stall=1. Go to WAIT when mem_req_ready==1.
- WAIT: mem_req_valid=0, stall=1. On mem_rsp_valid go to RESP.
  - Load without error: data_rd<=mem_rsp_rdata.
  - Store: data_rd<=0.
  - Error: data_rd<=0 and access_fault<=1.
- Response in the same cycle as the handshake is not allowed by the bus protocol. Responses are sampled only in WAIT; a mem_rsp_valid in IDLE/REQ/RESP is ignored (stray response after reset).
- Timeout: counter clears on entering REQ and increments each cycle in REQ/WAIT. When it reaches TIMEOUT_CYCLES (if nonzero), go to RESP with data_rd=0 and access_fault=1.
  - mem_req_valid drops even if it was never accepted.
  - A late response is then ignored.
- RESP: stall=0 for exactly one cycle, so the pipeline captures LSU rdata at this edge. access_fault is high only in RESP. Then go unconditionally to IDLE; cs is not sampled in RESP because it still reflects the retiring instruction.
- data_rd holds its value outside RESP updates.
- Latency with ready and response both on first opportunity:
  - Cycles from first cs==0: IDLE(stall) -> REQ -> WAIT -> RESP.
  - Total: 4 cycles, 3 stalled.
  - Back-to-back accesses therefore issue one every 4 cycles minimum.
- stall = (IDLE && !cs) | REQ | WAIT.

Decomposition:
- Package dmem_bus_pkg:
  - state enum dmem_state_e {IDLE, REQ, WAIT, RESP}.
  - CS_ACTIVE=1'b0 and WR_STORE=1'b0 constants.
  - A request struct {we, be, addr, wdata}.
- Optional sub-module dmem_timeout_ctr (clear/enable/expire, parameterised limit). All else sits inline.

Test Plan:
- Load: cs=0, wr=1, addr=0x104, memory ready immediately and responds next cycle with 0xDEADBEEF -> mem_req_addr=0x104, we=0; stall high 3 cycles; in RESP data_rd=0xDEADBEEF, stall=0, no fault.
- Byte store: cs=0, wr=0, mask=4'b0100, addr=0x203, data_wr=0x00AB0000, ready held low 5 cycles -> payload stable all 5 cycles; mem_req_addr=0x200, be=0100; stall persists until RESP; data_rd=0.
- Zero-mask store: cs=0, wr=0, mask=0 -> no mem_req_valid ever; stall high 1 cycle; RESP next; back to IDLE.
- Bus error: load, response with mem_rsp_err=1 and rdata=0x12345678 -> data_rd=0, access_fault pulses 1 cycle in RESP.
- Timeout with TIMEOUT_CYCLES=8: ready never asserted -> after 8 cycles in REQ, RESP with fault; late mem_rsp_valid 3 cycles later is ignored; state IDLE.
- Reset mid-WAIT: assert rst -> mem_req_valid=0, stall=0, data_rd=0 immediately; a subsequent response is ignored; the next load completes normally.
